timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised bank of `NUM_CH` independent down-counting timers behind one bridge device slot. It is the successor to the fixed two-instance single-mode timer arrangement. Each channel adds:
- selectable one-shot or auto-reload mode,
- a power-of-two prescaler,
- a sticky, maskable, write-1-to-clear interrupt flag.

Per-channel IRQ lines feed the CPU's `HWInt` vector directly.

## Interface
Parameters:
- `NUM_CH`, 2, number of channels; legal range 1..8.
- `CNT_W`, 32, counter/preset width; legal range 8..32. Upper `DAT_O` bits read 0.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state while low.
- `ADD_I`  in  8  byte address from bridge. `[6:4]` = channel, `[3:2]` = register, `[1:0]` ignored.
- `WE_I`  in  1  write strobe, sampled at rising edge.
- `DAT_I`  in  32  write data.
- `DAT_O`  out  32  read data; combinational from `ADD_I`.
- `IRQ_O`  out  NUM_CH  per-channel interrupt, level; bit i = channel i.

## Operation
Per-channel registers:
- `CTRL` (0x0), RW:
  - `[0]` EN
  - `[2:1]` MODE: 00 one-shot, 01 auto-reload, 1x treated as one-shot
  - `[3]` IM, interrupt enable
  - `[11:8]` PS: one tick per 2^PS clocks
  - other bits read 0
- `PRESET` (0x4), RW, `CNT_W` bits.
- `COUNT` (0x8), read-only; writes ignored.
- `STAT` (0xC):
  - `[0]` PEND, sticky
  - `[2:1]` current state encoding
  - write 1 to bit 0 clears PEND

Addressing:
- Channel index ≥ `NUM_CH`: reads 0, writes ignored.
- Register bits above the defined fields: reads 0.

Channel FSM (`IDLE`=0, `LOAD`=1, `CNT`=2, `INT`=3):
- `IDLE`: go to `LOAD` when EN=1.
- `LOAD`: COUNT←PRESET, prescaler←0, go to `CNT`.
- `CNT`:
  - EN=0 → `IDLE`, COUNT holds.
  - Otherwise, on tick: if COUNT≤1 then COUNT←0, PEND←1, go to `INT`; else COUNT←COUNT−1.
  - PRESET 0 and PRESET 1 both expire on the first tick.
- `INT`:
  - one-shot: EN←0, go to `IDLE`.
  - auto-reload: go to `LOAD`, unless EN was cleared, in which case go to `IDLE`.

Tick and interrupt rules:
- Tick occurs in `CNT` when prescaler == 2^PS−1; the prescaler then wraps to 0.
- The prescaler is 15 bits and free-runs only in `CNT`.
- `IRQ_O[i]` = PEND & IM. Toggling IM does not change PEND.

Boundary rules:
- PRESET written mid-count takes effect at the next `LOAD` only.
- CTRL write with EN=0 takes effect at the next edge: `CNT`/`LOAD` go to `IDLE`, and a one-shot `INT` completes normally.
- Expiry and PEND clear in the same cycle: set wins, PEND stays 1.
- Software EN←1 and hardware EN←0 (one-shot `INT`) in the same cycle: software wins, and the FSM goes `INT`→`IDLE`→`LOAD`.

Reset values: CTRL=0, PRESET=0, COUNT=0, PEND=0, state `IDLE`, prescaler 0, `IRQ_O`=0. `DAT_O` follows the address; it reads 0 from reset registers.

## Timing
- Register write is visible on `DAT_O` the cycle after the write edge.
- EN written at edge k: `LOAD` at k+1, `CNT` with COUNT=PRESET at k+2.
- With PS=0 and PRESET=N≥1: COUNT=0, PEND=1 and IRQ high (if IM) after edge k+2+N.
- Auto-reload period is (N·2^PS)+2 clocks between PEND-set edges.
- Asynchronous reset mid-count: all outputs return to reset values immediately. First activity is one edge after `reset` rises; no state survives.

## Structure
- Package `timer_bank_pkg`:
  - register offsets
  - MODE encodings
  - state enum `tb_state_t`
  - CTRL field bit positions
  - `NUM_CH`/`CNT_W` legality checks
- Sub-module `timer_channel`:
  - holds registers, prescaler and FSM for one channel
  - instantiated `NUM_CH` times in a generate loop
- Top-level `timer_bank` does address decode, per-channel write enables and the `DAT_O` read mux.

## Test plan
- Reset low mid-count with PEND=1 → `IRQ_O`=0, all registers read 0 immediately.
- Ch0, PRESET=5, CTRL=0x9 (EN, one-shot, IM) written at edge k → `IRQ_O[0]` rises after edge k+7; EN reads 0 after k+8; COUNT stays 0.
- Ch1, PRESET=3, CTRL=0xB (auto-reload) → PEND set every 5 clocks. Write STAT=1 the same cycle as an expiry → PEND stays 1.
- Ch0, PS=2, PRESET=2 → expiry 8 clocks after entering `CNT`. Clear EN mid-count with COUNT=1 → `IDLE`, COUNT holds 1, no IRQ.
- `NUM_CH`=3, write to channel 5 → no channel changes; channel 5 reads 0. PRESET=0 → expiry on first tick.
- Ch0 and ch1 expire in the same cycle → both `IRQ_O` bits high. W1C on ch0 → only bit 0 drops.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: shared types and constants for the timer bank.
// Register offsets, MODE codes, channel state enum, CTRL layout, checks.
package timer_bank_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STAT   = 2'd3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM   = 3;
   localparam int CTRL_PS   = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } tb_state_t;

   typedef struct packed {
      logic [3:0] ps;
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

   function automatic bit params_ok(int nch, int cw);
      return (nch >= 1) && (nch <= 8) &&
             (cw >= 8) && (cw <= 32);
   endfunction

   function automatic logic [31:0] ctrl_rd(ctrl_t c);
      return {20'd0, c.ps, 4'd0, c.im, c.mode, c.en};
   endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counting timer with prescaler, FSM and IRQ.
// Ports: clk, reset(async low), we/rg/wdata write, rdata read, irq level.
module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  rg,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   ctrl_t            ctrl;
   logic [CNT_W-1:0] preset;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_d;
   logic [14:0]      psc;
   logic [14:0]      psc_d;
   logic [14:0]      lim;
   logic             pend;
   logic             tick;
   logic             expire;
   logic             hw_dis;
   logic             wr_ctrl;
   logic             wr_preset;
   logic             wr_stat;
   logic             unused_wd;
   tb_state_t        state;
   tb_state_t        state_d;

   assign wr_ctrl   = we && (rg == REG_CTRL);
   assign wr_preset = we && (rg == REG_PRESET);
   assign wr_stat   = we && (rg == REG_STAT);
   assign unused_wd = ^wdata[31:12];

   // 2^PS - 1; PS=15 wraps the 16-bit shift to the full 15-bit mask
   assign lim  = 15'((16'd1 << ctrl.ps) - 16'd1);
   assign tick = (psc == lim);
   assign irq  = pend & ctrl.im;

   always_comb begin
      state_d = state;
      count_d = count;
      psc_d   = psc;
      expire  = 1'b0;
      hw_dis  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (ctrl.en) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (!ctrl.en) begin
               state_d = S_IDLE;
            end else begin
               count_d = preset;
               psc_d   = '0;
               state_d = S_CNT;
            end
         end
         S_CNT: begin
            if (!ctrl.en) begin
               state_d = S_IDLE;
            end else begin
               psc_d = tick ? '0 : psc + 15'd1;
               if (tick) begin
                  if (count <= CNT_W'(1)) begin
                     count_d = '0;
                     expire  = 1'b1;
                     state_d = S_INT;
                  end else begin
                     count_d = count - CNT_W'(1);
                  end
               end
            end
         end
         S_INT: begin
            if (ctrl.mode == MODE_AUTO && ctrl.en) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
               hw_dis  = (ctrl.mode != MODE_AUTO);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         count     <= '0;
         psc       <= '0;
         pend      <= 1'b0;
         preset    <= '0;
         ctrl.ps   <= '0;
         ctrl.im   <= 1'b0;
         ctrl.mode <= MODE_ONESHOT;
         ctrl.en   <= 1'b0;
      end else begin
         state <= state_d;
         count <= count_d;
         psc   <= psc_d;
         // expiry beats a same-cycle clear
         if (expire)
            pend <= 1'b1;
         else if (wr_stat && wdata[0])
            pend <= 1'b0;
         // software write beats the one-shot auto-disable
         if (wr_ctrl) begin
            ctrl.ps   <= wdata[CTRL_PS +: 4];
            ctrl.im   <= wdata[CTRL_IM];
            ctrl.mode <= wdata[CTRL_MODE +: 2];
            ctrl.en   <= wdata[CTRL_EN];
         end else if (hw_dis) begin
            ctrl.en <= 1'b0;
         end
         if (wr_preset)
            preset <= wdata[CNT_W-1:0];
      end
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         (rg == REG_CTRL):   rdata = ctrl_rd(ctrl);
         (rg == REG_PRESET): rdata = 32'(preset);
         (rg == REG_COUNT):  rdata = 32'(count);
         (rg == REG_STAT):   rdata = {29'd0, state, pend};
      endcase
   end

endmodule

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH timer channels behind one bridge slot.
// Ports: clk, reset(async low), ADD_I/WE_I/DAT_I bus in, DAT_O, IRQ_O.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        ADD_I,
   input  logic              WE_I,
   input  logic [31:0]       DAT_I,
   output logic [31:0]       DAT_O,
   output logic [NUM_CH-1:0] IRQ_O
);

   logic [2:0]        ch;
   logic [1:0]        rg;
   logic [NUM_CH-1:0] we;
   logic [31:0]       rd [NUM_CH];
   logic              unused_add;

   assign ch         = ADD_I[6:4];
   assign rg         = ADD_I[3:2];
   assign unused_add = ^{ADD_I[7], ADD_I[1:0]};

   if (!params_ok(NUM_CH, CNT_W)) begin : g_bad
      $error("timer_bank: NUM_CH or CNT_W out of range");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign we[i] = WE_I && (ch == 3'(i));

      timer_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .we    (we[i]),
         .rg    (rg),
         .wdata (DAT_I),
         .rdata (rd[i]),
         .irq   (IRQ_O[i])
      );
   end

   // unpopulated channel slots read as zero
   always_comb begin
      DAT_O = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch == 3'(i)) DAT_O = rd[i];
   end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed bench for timer_bank, 3 channels, 16-bit count.
// Driver queues expected values; a negedge monitor pops and compares.
module tb_timer_bank;

   logic        clk;
   logic        reset;
   logic [7:0]  ADD_I;
   logic        WE_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic [2:0]  IRQ_O;

   typedef struct {
      string       name;
      bit          is_irq;
      logic [31:0] exp;
   } sb_t;

   sb_t sbq[$];
   int  n_chk;
   int  n_fail;

   timer_bank #(
      .NUM_CH (3),
      .CNT_W  (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ADD_I (ADD_I),
      .WE_I  (WE_I),
      .DAT_I (DAT_I),
      .DAT_O (DAT_O),
      .IRQ_O (IRQ_O)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         sb_t         e;
         logic [31:0] act;
         e   = sbq.pop_front();
         act = e.is_irq ? 32'(IRQ_O) : DAT_O;
         n_chk++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h",
                     e.name, act, e.exp);
         end
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(logic [7:0] a, logic [31:0] d);
      ADD_I = a;
      DAT_I = d;
      WE_I  = 1'b1;
      cyc();
      WE_I  = 1'b0;
   endtask

   task automatic rd(string nm, logic [7:0] a, logic [31:0] e);
      sb_t s;
      ADD_I    = a;
      s.name   = nm;
      s.is_irq = 1'b0;
      s.exp    = e;
      sbq.push_back(s);
      cyc();
   endtask

   task automatic irq(string nm, logic [2:0] e);
      sb_t s;
      s.name   = nm;
      s.is_irq = 1'b1;
      s.exp    = 32'(e);
      sbq.push_back(s);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b0;
      ADD_I  = '0;
      WE_I   = 1'b0;
      DAT_I  = '0;
      cyc(2);
      reset = 1'b1;
      cyc();

      // reset state
      rd("rst_ctrl0", 8'h00, 0);
      rd("rst_stat0", 8'h0C, 0);
      irq("rst_irq", 3'b000);
      rd("rst_preset1", 8'h14, 0);

      // ch0 one-shot, PRESET=5
      wr(8'h04, 5);
      wr(8'h00, 32'h9);
      rd("a_stat_k", 8'h0C, 0);
      rd("a_stat_load", 8'h0C, 2);
      rd("a_cnt_preset", 8'h08, 5);
      rd("a_cnt_dec", 8'h08, 4);
      irq("a_irq_early", 3'b000);
      rd("a_stat_cnt", 8'h0C, 4);
      cyc();
      irq("a_irq_pre", 3'b000);
      rd("a_cnt_one", 8'h08, 1);
      irq("a_irq_set", 3'b001);
      rd("a_stat_int", 8'h0C, 7);
      rd("a_ctrl_en0", 8'h00, 8);
      irq("a_irq_hold", 3'b001);
      rd("a_cnt_zero", 8'h08, 0);
      rd("a_stat_idle", 8'h0C, 1);
      wr(8'h0C, 1);
      irq("a_w1c", 3'b000);
      rd("a_stat_clr", 8'h0C, 0);

      // ch1 auto-reload, PRESET=3
      wr(8'h14, 3);
      wr(8'h10, 32'hB);
      cyc(5);
      irq("b_irq", 3'b010);
      rd("b_stat_int", 8'h1C, 7);
      wr(8'h1C, 1);
      irq("b_clr", 3'b000);
      rd("b_stat_cnt", 8'h1C, 4);
      cyc();
      wr(8'h1C, 1);
      irq("b_set_wins", 3'b010);
      rd("b_stat_race", 8'h1C, 7);
      rd("b_stat_reload", 8'h1C, 3);
      rd("b_cnt_reload", 8'h18, 3);
      cyc();
      rd("b_cnt_one", 8'h18, 1);
      rd("b_stat_int2", 8'h1C, 7);
      wr(8'h10, 0);
      rd("b_ctrl_off", 8'h10, 0);
      rd("b_stat_off", 8'h1C, 1);
      rd("b_cnt_hold", 8'h18, 3);
      wr(8'h1C, 1);
      irq("b_irq_off", 3'b000);
      rd("b_stat_zero", 8'h1C, 0);

      // ch0 PS=2, PRESET=2
      wr(8'h04, 2);
      wr(8'h00, 32'h209);
      rd("c_ctrl", 8'h00, 32'h209);
      cyc(8);
      irq("c_irq_pre", 3'b000);
      rd("c_cnt_one", 8'h08, 1);
      irq("c_irq", 3'b001);
      rd("c_stat_int", 8'h0C, 7);
      rd("c_ctrl_done", 8'h00, 32'h208);
      wr(8'h0C, 1);

      // same, EN cleared while COUNT=1
      wr(8'h00, 32'h209);
      cyc(5);
      rd("c2_cnt_two", 8'h08, 2);
      wr(8'h00, 32'h208);
      rd("c2_cnt", 8'h08, 1);
      rd("c2_stat_idle", 8'h0C, 0);
      cyc(12);
      irq("c2_no_irq", 3'b000);
      rd("c2_cnt_hold", 8'h08, 1);

      // unpopulated channel 5, field masking, read-only COUNT
      wr(8'h54, 32'hAB);
      wr(8'h50, 32'h9);
      rd("d_ch5_ctrl", 8'h50, 0);
      rd("d_ch5_preset", 8'h54, 0);
      rd("d_ch0_preset", 8'h04, 2);
      rd("d_ch1_preset", 8'h14, 3);
      rd("d_ch2_ctrl", 8'h20, 0);
      irq("d_irq", 3'b000);
      wr(8'h24, 32'hFFFF_FFFF);
      rd("d_preset_w", 8'h24, 32'h0000_FFFF);
      wr(8'h20, 32'hFFFF_FFF6);
      rd("d_ctrl_mask", 8'h20, 32'h0000_0F06);
      wr(8'h28, 32'h1234);
      rd("d_cnt_ro", 8'h28, 0);

      // ch2 PRESET=0 expires on first tick
      wr(8'h24, 0);
      wr(8'h20, 32'h9);
      cyc(2);
      rd("d_p0_stat_cnt", 8'h2C, 4);
      irq("d_p0_irq", 3'b100);
      rd("d_p0_stat", 8'h2C, 7);
      rd("d_p0_ctrl", 8'h20, 8);
      wr(8'h2C, 1);
      irq("d_p0_clr", 3'b000);

      // ch0 and ch1 expire together
      wr(8'h00, 0);
      wr(8'h04, 4);
      wr(8'h14, 3);
      wr(8'h00, 32'h9);
      wr(8'h10, 32'h9);
      cyc(4);
      irq("e_pre", 3'b000);
      cyc();
      irq("e_both", 3'b011);
      wr(8'h0C, 1);
      irq("e_w1c0", 3'b010);
      rd("e_stat1", 8'h1C, 1);
      rd("e_stat0", 8'h0C, 0);
      wr(8'h10, 0);
      irq("e_im_off", 3'b000);
      rd("e_pend_kept", 8'h1C, 1);
      wr(8'h10, 32'h8);
      irq("e_im_on", 3'b010);
      wr(8'h1C, 1);
      irq("e_clr1", 3'b000);

      // software EN=1 against one-shot auto-disable
      wr(8'h04, 1);
      wr(8'h00, 32'h9);
      cyc(3);
      irq("f_irq", 3'b001);
      wr(8'h00, 32'h9);
      rd("f_ctrl", 8'h00, 32'h9);
      rd("f_stat_load", 8'h0C, 3);

      // async reset while counting with PEND set
      wr(8'h14, 3);
      wr(8'h10, 32'hB);
      cyc(6);
      irq("g_pre", 3'b011);
      cyc();
      reset = 1'b0;
      irq("g_irq", 3'b000);
      rd("g_stat0", 8'h0C, 0);
      rd("g_ctrl1", 8'h10, 0);
      rd("g_preset0", 8'h04, 0);
      reset = 1'b1;
      cyc(3);
      rd("g_stat1", 8'h1C, 0);
      rd("g_cnt1", 8'h18, 0);
      irq("g_irq_after", 3'b000);

      cyc(2);
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d left, expected 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
